// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock (LO=quotient, HI=remainder).
// Optional macro DIV_UNSIGNED_EN adds the is_unsigned input for unsigned division. Rev 1.0
`default_nettype none

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic               w_uns;
  logic               w_dd_neg;
  logic               w_dv_neg;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;

`ifdef DIV_UNSIGNED_EN
  assign w_uns = is_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  assign w_dd_neg = ~w_uns & dividend[WIDTH-1];
  assign w_dv_neg = ~w_uns & divisor[WIDTH-1];

  // Partial remainder needs WIDTH+1 bits: with unsigned operands it can exceed 2^WIDTH-1 after the shift.
  assign w_shift = {rem_q, q_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, dvsr_q};
  assign w_ge    = (w_shift >= {1'b0, dvsr_q});

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            dvsr_d  = w_dv_neg ? -divisor : divisor;
            q_d     = w_dd_neg ? -dividend : dividend;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            qneg_d  = w_dd_neg ^ w_dv_neg;
            rneg_d  = w_dd_neg;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], w_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = qneg_q ? -q_q : q_q;
        remainder_d = rneg_q ? -rem_q : rem_q;
        state_d     = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq against an arithmetic reference model.
`default_nettype none

module tb_div_seq;

  logic        clock;
  logic        clear;
  logic        start;
  logic        is_uns;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  div_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned (is_uns),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic uns);
    exp_t   e;
    longint sa, sb_, sq, sr;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (uns) begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end else begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      sq  = sa / sb_;
      sr  = sa % sb_;
      e.q  = sq[31:0];
      e.r  = sr[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: q=%h r=%h dz=%0b with no outstanding request", quotient, remainder, div_by_zero);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          errors++;
          $display("FAIL result: got q=%h r=%h dz=%0b, expected q=%h r=%h dz=%0b",
                   quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Issue one division; optionally pulse a stray start mid-operation; check latency and busy length.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns, input bit stray);
    int  edges;
    int  busy_cnt;
    bit  seen;
    int  want_lat;
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    is_uns   = uns;
    sb.push_back(model(a, b, uns));
    want_lat = (b == 32'd0) ? 1 : 34;
    @(posedge clock);
    edges    = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      start    = (stray && edges == 5);
      dividend = $urandom;
      divisor  = $urandom;
      is_uns   = 1'($urandom_range(0, 1));
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clock);
      edges++;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout: no done within 60 edges for %h / %h", a, b);
    end else begin
      check("latency", 32'(edges), 32'(want_lat));
      check("busy_cycles", 32'(busy_cnt), 32'(want_lat - 1));
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        u;
    start    = 1'b0;
    is_uns   = 1'b0;
    dividend = '0;
    divisor  = '0;
    clear    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1);
    run_op(32'd7, 32'd0, 1'b0, 1'b0);
    check("dbz_held", 32'(div_by_zero), 32'd1);
    run_op(32'd9, 32'd3, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b0);
`ifdef DIV_UNSIGNED_EN
    run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0);
`endif

    // Abort: stray start at cycle 5, clear at cycle 10; no done may appear.
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = (c == 5);
      if (c == 5) begin dividend = 32'd50; divisor = 32'd5; end
      clear = (c == 10);
      @(posedge clock);
    end
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clock);
    run_op(32'd50, 32'd5, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        3: b = $urandom;
        default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
      endcase
`ifdef DIV_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
`else
      u = 1'b0;
`endif
      run_op(a, b, u, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
